// File: rtl/serial_twos_rx.sv
// Bit-serial two's-complement receiver: undoes an on-the-fly negation of an
// LSB-first stream and presents raw and recovered words over valid/ready.
module serial_twos_rx #(
  parameter int WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic             s_in,
  input  logic             s_en,
  input  logic             s_start,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] raw,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             ovf,
  output logic             overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Most-negative word: its negation is not representable in WIDTH bits.
  function automatic logic is_most_neg(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] mn;
    mn = '0;
    mn[WIDTH-1] = 1'b1;
    return (w == mn);
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s, bit_idx_s;
  logic             seen_r, seen_nxt_s, seen_prev_s;
  logic [WIDTH-1:0] dsh_r, dsh_nxt_s, rsh_r, rsh_nxt_s;
  logic             take_s, frame_start_s, dec_bit_s, complete_s;

  // Bit capture, serial decode and frame-completion detection.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    seen_nxt_s    = seen_r;
    dsh_nxt_s     = dsh_r;
    rsh_nxt_s     = rsh_r;
    complete_s    = 1'b0;
    frame_start_s = s_en & s_start;
    take_s        = 1'b0;
    case (state_r)
      IDLE:    take_s = frame_start_s;
      SHIFT:   take_s = s_en;
      default: take_s = 1'b0;
    endcase
    // A start bit always restarts the frame, discarding any partial one.
    if (frame_start_s) begin
      bit_idx_s   = '0;
      seen_prev_s = 1'b0;
      dsh_nxt_s   = '0;
      rsh_nxt_s   = '0;
    end else begin
      bit_idx_s   = cnt_r;
      seen_prev_s = seen_r;
    end
    dec_bit_s = seen_prev_s ? ~s_in : s_in;
    if (take_s) begin
      dsh_nxt_s[bit_idx_s] = dec_bit_s;
      rsh_nxt_s[bit_idx_s] = s_in;
      seen_nxt_s           = seen_prev_s | s_in;
      if (bit_idx_s == LAST_IDX) begin
        complete_s  = 1'b1;
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end else begin
        state_nxt_s = SHIFT;
        cnt_nxt_s   = bit_idx_s + CW'(1);
      end
    end else begin
      complete_s = 1'b0;
    end
  end

  // Frame-assembly state: FSM, bit counter, seen_one and shift registers.
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      seen_r  <= 1'b0;
      dsh_r   <= '0;
      rsh_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      seen_r  <= seen_nxt_s;
      dsh_r   <= dsh_nxt_s;
      rsh_r   <= rsh_nxt_s;
    end
  end

  // Output registers and handshake; a completion with a stalled word is dropped.
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      dout       <= '0;
      raw        <= '0;
      ovf        <= 1'b0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (complete_s) begin
        if (!dout_valid || dout_ready) begin
          dout       <= dsh_nxt_s;
          raw        <= rsh_nxt_s;
          ovf        <= is_most_neg(rsh_nxt_s);
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end else begin
        dout_valid <= dout_valid;
      end
    end
  end

endmodule

// File: tb/tb_serial_twos_rx.sv
// Directed self-checking bench for serial_twos_rx with WIDTH=8.
module tb_serial_twos_rx;

  localparam int WIDTH = 8;

  logic             t_clk;
  logic             r_n;
  logic             s_in;
  logic             s_en;
  logic             s_start;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] raw;
  logic             dout_valid;
  logic             dout_ready;
  logic             ovf;
  logic             overrun;

  int n_checks = 0;
  int n_fail   = 0;

  serial_twos_rx #(.WIDTH(WIDTH)) dut (
    .t_clk      (t_clk),
    .r_n        (r_n),
    .s_in       (s_in),
    .s_en       (s_en),
    .s_start    (s_start),
    .dout       (dout),
    .raw        (raw),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf        (ovf),
    .overrun    (overrun)
  );

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One qualified bit; returns 1 ns after the capturing edge.
  task automatic send_bit(input logic b, input logic st);
    @(negedge t_clk);
    s_in = b; s_en = 1'b1; s_start = st;
    @(posedge t_clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge t_clk);
      s_en = 1'b0; s_start = 1'b0; s_in = 1'b0;
      @(posedge t_clk);
      #1;
    end
  endtask

  // Full frame LSB-first; optionally gaps between bits and a check that no
  // completion has happened before the last bit.
  task automatic send_frame(input logic [WIDTH-1:0] v, input bit gap, input bit chk_pre);
    for (int i = 0; i < WIDTH; i++) begin
      if (gap && i > 0) idle_cycles(1);
      if (i == WIDTH - 1 && chk_pre) check_val("pre_last_valid", {31'b0, dout_valid}, 32'h0);
      send_bit(v[i], (i == 0) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    r_n = 1'b0; s_in = 1'b0; s_en = 1'b0; s_start = 1'b0; dout_ready = 1'b1;
    #23;
    check_val("rst_dout",    {24'b0, dout}, 32'h0);
    check_val("rst_raw",     {24'b0, raw}, 32'h0);
    check_val("rst_valid",   {31'b0, dout_valid}, 32'h0);
    check_val("rst_ovf",     {31'b0, ovf}, 32'h0);
    check_val("rst_overrun", {31'b0, overrun}, 32'h0);
    r_n = 1'b1;
    idle_cycles(2);

    // 0xFB -> 0x05
    send_frame(8'hFB, 1'b0, 1'b1);
    check_val("fb_dout",  {24'b0, dout}, 32'h05);
    check_val("fb_raw",   {24'b0, raw}, 32'hFB);
    check_val("fb_valid", {31'b0, dout_valid}, 32'h1);
    check_val("fb_ovf",   {31'b0, ovf}, 32'h0);
    idle_cycles(1);
    check_val("fb_valid_drop", {31'b0, dout_valid}, 32'h0);

    // Most-negative and zero words
    send_frame(8'h80, 1'b0, 1'b1);
    check_val("80_dout", {24'b0, dout}, 32'h80);
    check_val("80_raw",  {24'b0, raw}, 32'h80);
    check_val("80_ovf",  {31'b0, ovf}, 32'h1);
    idle_cycles(1);
    send_frame(8'h00, 1'b0, 1'b1);
    check_val("00_dout",  {24'b0, dout}, 32'h00);
    check_val("00_raw",   {24'b0, raw}, 32'h00);
    check_val("00_ovf",   {31'b0, ovf}, 32'h0);
    check_val("00_valid", {31'b0, dout_valid}, 32'h1);
    idle_cycles(1);

    // 0x05 with gaps between qualified bits
    send_frame(8'h05, 1'b1, 1'b1);
    check_val("05_dout",  {24'b0, dout}, 32'hFB);
    check_val("05_raw",   {24'b0, raw}, 32'h05);
    check_val("05_valid", {31'b0, dout_valid}, 32'h1);
    idle_cycles(2);

    // Stalled consumer: second word dropped, overrun sticky
    dout_ready = 1'b0;
    send_frame(8'h01, 1'b0, 1'b1);
    check_val("st1_dout",    {24'b0, dout}, 32'hFF);
    check_val("st1_overrun", {31'b0, overrun}, 32'h0);
    send_frame(8'h02, 1'b0, 1'b0);
    check_val("st2_dout",    {24'b0, dout}, 32'hFF);
    check_val("st2_raw",     {24'b0, raw}, 32'h01);
    check_val("st2_valid",   {31'b0, dout_valid}, 32'h1);
    check_val("st2_overrun", {31'b0, overrun}, 32'h1);
    @(negedge t_clk);
    dout_ready = 1'b1;
    s_en = 1'b0; s_start = 1'b0;
    @(posedge t_clk);
    #1;
    check_val("st_valid_drop", {31'b0, dout_valid}, 32'h0);
    check_val("st_overrun_hold", {31'b0, overrun}, 32'h1);

    // Restart after 4 bits, then a full 0x03 frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_frame(8'h03, 1'b0, 1'b1);
    check_val("rs_dout",  {24'b0, dout}, 32'hFD);
    check_val("rs_raw",   {24'b0, raw}, 32'h03);
    check_val("rs_valid", {31'b0, dout_valid}, 32'h1);
    idle_cycles(1);
    check_val("rs_single", {31'b0, dout_valid}, 32'h0);

    // Asynchronous reset mid-frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    #2;
    r_n = 1'b0;
    #1;
    check_val("ar_dout",    {24'b0, dout}, 32'h0);
    check_val("ar_raw",     {24'b0, raw}, 32'h0);
    check_val("ar_overrun", {31'b0, overrun}, 32'h0);
    #1;
    r_n = 1'b1;
    idle_cycles(1);
    // Bits without a start must be ignored after the partial frame was discarded
    for (int i = 0; i < WIDTH; i++) send_bit(1'b1, 1'b0);
    check_val("ar_no_start", {31'b0, dout_valid}, 32'h0);
    idle_cycles(1);
    send_frame(8'h02, 1'b0, 1'b1);
    check_val("ar2_dout",  {24'b0, dout}, 32'hFE);
    check_val("ar2_raw",   {24'b0, raw}, 32'h02);
    check_val("ar2_valid", {31'b0, dout_valid}, 32'h1);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_twos_rx.md
Name: serial_twos_rx

Overview:
- Bit-serial receiver at the far end of the serial two's-complement link: accepts an LSB-first stream of complemented bits and undoes the negation on the fly.
- Reassembles each frame into a WIDTH-bit parallel word and presents both the raw received word and the recovered (re-negated) word through a valid/ready handshake.
- Sits between the serial complementer output and parallel consumer logic, on the same t_clk domain.

Parameters:
WIDTH, 8, bits per frame (>=2)

Ports:
t_clk  input  1  clock; all state updates on rising edge
r_n  input  1  asynchronous active-low reset
s_in  input  1  serial data bit, LSB first
s_en  input  1  s_in is valid this cycle
s_start  input  1  qualified by s_en; marks bit 0 of a frame
dout  output  WIDTH  recovered word = two's complement of raw
raw  output  WIDTH  word exactly as received
dout_valid  output  1  dout/raw hold a completed frame
dout_ready  input  1  consumer accepts the word when dout_valid=1
ovf  output  1  raw == 2^(WIDTH-1) (most-negative; negation not representable); valid with dout_valid
overrun  output  1  sticky: a completed frame was dropped

Behaviour:
- Reset (r_n=0, immediate): state IDLE, bit counter 0, seen_one 0, shift regs 0, dout=0, raw=0, dout_valid=0, ovf=0, overrun=0. Reset mid-frame discards the partial frame.
- States: IDLE (no frame in progress), SHIFT (collecting bits).
- IDLE: s_en&s_start -> SHIFT, capture bit 0. s_en without s_start is ignored.
- SHIFT: each s_en cycle captures one bit and increments the counter. s_en=0 holds all state; gaps are allowed.
- s_en&s_start while in SHIFT: abort the partial frame and restart with this bit as bit 0. No output and no flag.
- Decode per bit: d = seen_one ? ~s_in : s_in, using seen_one from before this bit. Then seen_one |= s_in. seen_one clears at each frame start, before bit 0 is decoded.
- Bit k of the decoded stream goes to dout position k; s_in goes to raw position k.
- Completion: on the edge that captures bit WIDTH-1, the output registers load dout/raw/ovf and dout_valid=1 on that same edge. State returns to IDLE.
- The shift registers are separate from the output registers, so the next frame may shift while dout_valid is held.
- Handshake: the transfer occurs on an edge where dout_valid&dout_ready. dout_valid falls on that edge unless a new frame completes on the same edge; in that case the new word loads and dout_valid stays 1, with no overrun.
- Completion while dout_valid=1 and dout_ready=0: the new word is dropped, output registers are unchanged, and overrun=1 from the next edge. overrun clears only on reset.
- dout, raw and ovf are stable while dout_valid=1 and dout_ready=0.
- Arithmetic: dout = (~raw + 1) mod 2^WIDTH. raw=0 gives dout=0 with ovf=0. raw=2^(WIDTH-1) gives dout=raw with ovf=1.

Test Plan:
- WIDTH=8, dout_ready=1; stream 0xFB LSB-first (1,1,0,1,1,1,1,1), s_start on the first bit, s_en continuous -> on the 8th bit's edge: dout=0x05, raw=0xFB, dout_valid=1 for one cycle, ovf=0.
- Stream 0x80 (0,0,0,0,0,0,0,1) -> dout=0x80, raw=0x80, ovf=1. Stream 0x00 -> dout=0x00, ovf=0.
- Stream 0x05 with s_en toggling every other cycle -> dout=0xFB, raw=0x05. Completion occurs only on the edge of the 8th qualified bit.
- dout_ready=0; send 0x01 then 0x02 back-to-back -> dout stays 0xFF, raw stays 0x01, overrun=1. Then raise dout_ready -> dout_valid drops after one edge; overrun remains 1.
- Assert s_start again after 4 bits of a frame, then send a full 0x03 frame -> only one completion: dout=0xFD, raw=0x03.
- Pull r_n low mid-frame for a partial cycle -> all outputs 0 immediately. A subsequent full 0x02 frame -> dout=0xFE.
